// File: rtl/stream_merge_2to1_pkg.sv
// -----------------------------------------------------------------------------
// stream_merge_2to1_pkg
// Shared definitions for the 2:1 packet-aware stream merge.
//   CH0 / CH1     : channel identifiers, also the encoding of out_src
//   state_t       : merge FSM state (IDLE, LOCK0, LOCK1)
//   DATA_W_DEF    : default data width
// -----------------------------------------------------------------------------
package stream_merge_2to1_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int DATA_W_DEF = 8;

  // IDLE  : no packet in flight, arbitration is open
  // LOCKn : channel n has started a packet and owns the output until its last beat
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

endpackage

// File: rtl/stream_merge_2to1_rr_arb2.sv
// -----------------------------------------------------------------------------
// stream_merge_2to1_rr_arb2 (module rr_arb2)
// Two-requester round-robin grant with a packet lock override. Purely
// combinational; the owner of rr_ptr and the lock state is the caller.
// Ports:
//   req0, req1  in  : request from channel 0 / 1
//   rr_ptr      in  : preferred channel when both request
//   lock        in  : a packet is in flight, grant is pinned to lock_ch
//   lock_ch     in  : channel that owns the lock
//   grant_valid out : a channel is granted this cycle
//   grant       out : granted channel (meaningful only with grant_valid)
// -----------------------------------------------------------------------------
module rr_arb2
  import stream_merge_2to1_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  input  logic lock,
  input  logic lock_ch,
  output logic grant_valid,
  output logic grant
);

  always_comb begin
    grant_valid = 1'b0;
    grant       = CH0;
    if (lock) begin
      // The lock holds even through bubbles on the owning channel, so the
      // other channel can never slip a beat into the middle of a packet.
      grant_valid = 1'b1;
      grant       = lock_ch;
    end else if (req0 && req1) begin
      grant_valid = 1'b1;
      grant       = rr_ptr;
    end else if (req0) begin
      grant_valid = 1'b1;
      grant       = CH0;
    end else if (req1) begin
      grant_valid = 1'b1;
      grant       = CH1;
    end
  end

endmodule

// File: rtl/stream_merge_2to1.sv
// -----------------------------------------------------------------------------
// stream_merge_2to1
// Merges two valid/ready packet streams onto one registered output stream.
// Round-robin between packets; once a channel's first beat is taken, that
// channel owns the output until its last beat. Each output beat carries the
// channel it came from on out_src.
//
// Handshake: a beat moves on any interface on a rising edge where valid and
// ready are both high. Producers hold valid/data/last stable until accepted;
// ready may be high without valid. out_ready feeds in0_ready/in1_ready
// combinationally so the output register can retire and reload on one edge.
//
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   in0_valid/in0_data/in0_last/in0_ready : channel 0 input stream
//   in1_valid/in1_data/in1_last/in1_ready : channel 1 input stream
//   out_valid/out_data/out_last/out_src   : registered output stream
//   out_ready                             : downstream accept
// -----------------------------------------------------------------------------
module stream_merge_2to1
  import stream_merge_2to1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
  input  logic              out_ready
);

  state_t state;
  logic   rr_ptr;

  logic grant_valid;
  logic grant;
  logic load_en;
  logic acc0;
  logic acc1;
  logic accept;
  logic acc_ch;
  logic acc_last;
  logic [DATA_W-1:0] acc_data;

  rr_arb2 u_arb (
    .req0        (in0_valid),
    .req1        (in1_valid),
    .rr_ptr      (rr_ptr),
    .lock        (state != IDLE),
    .lock_ch     (state == LOCK1),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // The output register can take a new beat when empty or being drained.
  assign load_en = !out_valid || out_ready;

  // Gated by rst_n so both readies drop the moment reset asserts, not just
  // after the registers clear.
  assign in0_ready = rst_n && load_en && grant_valid && (grant == CH0);
  assign in1_ready = rst_n && load_en && grant_valid && (grant == CH1);

  assign acc0     = in0_valid && in0_ready;
  assign acc1     = in1_valid && in1_ready;
  assign accept   = acc0 || acc1;
  assign acc_ch   = acc1 ? CH1 : CH0;
  assign acc_last = acc1 ? in1_last : in0_last;
  assign acc_data = acc1 ? in1_data : in0_data;

  // Output register: loads on accept, empties when drained with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= CH0;
    end else if (load_en) begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= acc_data;
        out_last  <= acc_last;
        out_src   <= acc_ch;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Packet lock FSM; rr_ptr moves only at a packet end, pointing away from
  // the channel that just finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= CH0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (acc_last) rr_ptr <= ~acc_ch;
            else          state  <= acc_ch ? LOCK1 : LOCK0;
          end
        end
        LOCK0, LOCK1: begin
          if (accept && acc_last) begin
            state  <= IDLE;
            rr_ptr <= ~acc_ch;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_merge_2to1.sv
// -----------------------------------------------------------------------------
// tb_stream_merge_2to1
// Directed test of stream_merge_2to1: reset, single-beat contention, packet
// lock, lock bubble, backpressure, single-channel traffic, reset mid-packet.
// Inputs change 1 ns after a rising edge; outputs are checked 1-2 ns after it.
// -----------------------------------------------------------------------------
module tb_stream_merge_2to1;

  localparam int DATA_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in0_valid = 1'b0;
  logic [DATA_W-1:0] in0_data  = '0;
  logic              in0_last  = 1'b0;
  logic              in0_ready;
  logic              in1_valid = 1'b0;
  logic [DATA_W-1:0] in1_data  = '0;
  logic              in1_last  = 1'b0;
  logic              in1_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_src;
  logic              out_ready = 1'b1;

  stream_merge_2to1 #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  // ---------------- checking ----------------
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk8(input string tag, input logic [DATA_W-1:0] obs,
                      input logic [DATA_W-1:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Checks a full output beat.
  task automatic chk_beat(input string tag, input logic [DATA_W-1:0] d,
                          input logic l, input logic s);
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chk8({tag, "_data"},  out_data,  d);
    chk1({tag, "_last"},  out_last,  l);
    chk1({tag, "_src"},   out_src,   s);
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk1({tag, "_rdy0"}, in0_ready, r0);
    chk1({tag, "_rdy1"}, in1_ready, r1);
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive0(input logic v, input logic [DATA_W-1:0] d, input logic l);
    in0_valid = v;
    in0_data  = d;
    in0_last  = l;
  endtask

  task automatic drive1(input logic v, input logic [DATA_W-1:0] d, input logic l);
    in1_valid = v;
    in1_data  = d;
    in1_last  = l;
  endtask

  logic [DATA_W-1:0] c0;
  logic [DATA_W-1:0] c1;
  logic              exp_ch;

  initial begin
    // ---- reset state ----
    #2;
    chk1("rst_valid", out_valid, 1'b0);
    chk8("rst_data",  out_data,  8'h00);
    chk1("rst_last",  out_last,  1'b0);
    chk1("rst_src",   out_src,   1'b0);
    chk_rdy("rst", 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---- single-beat contention: alternates 0,1,0,1 at one beat/cycle ----
    c0 = 8'h10;
    c1 = 8'h20;
    drive0(1'b1, c0, 1'b1);
    drive1(1'b1, c1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      settle();
      exp_ch = (i % 2 == 1);
      chk_rdy("rr", !exp_ch, exp_ch);
      tick();
      chk_beat("rr", exp_ch ? c1 : c0, 1'b1, exp_ch);
      if (exp_ch) c1 = c1 + 8'd1;
      else        c0 = c0 + 8'd1;
      in0_data = c0;
      in1_data = c1;
    end
    drive0(1'b0, 8'h00, 1'b0);
    drive1(1'b0, 8'h00, 1'b0);
    tick();
    chk1("rr_drain", out_valid, 1'b0);

    // ---- packet lock: A1,A2,A3 then B1 ----
    drive0(1'b1, 8'hA1, 1'b0);
    drive1(1'b1, 8'hB1, 1'b1);
    settle();
    chk_rdy("lock_a1", 1'b1, 1'b0);
    tick();
    chk_beat("lock_a1", 8'hA1, 1'b0, 1'b0);
    drive0(1'b1, 8'hA2, 1'b0);
    settle();
    chk_rdy("lock_a2", 1'b1, 1'b0);
    tick();
    chk_beat("lock_a2", 8'hA2, 1'b0, 1'b0);
    drive0(1'b1, 8'hA3, 1'b1);
    settle();
    chk_rdy("lock_a3", 1'b1, 1'b0);
    tick();
    chk_beat("lock_a3", 8'hA3, 1'b1, 1'b0);
    drive0(1'b0, 8'h00, 1'b0);
    settle();
    chk_rdy("lock_b1", 1'b0, 1'b1);
    tick();
    chk_beat("lock_b1", 8'hB1, 1'b1, 1'b1);
    drive1(1'b0, 8'h00, 1'b0);
    tick();
    chk1("lock_drain", out_valid, 1'b0);

    // ---- lock bubble: ch0 pauses two cycles mid-packet, ch1 waits ----
    drive0(1'b1, 8'hC1, 1'b0);
    drive1(1'b1, 8'hD1, 1'b1);
    tick();
    chk_beat("bub_c1", 8'hC1, 1'b0, 1'b0);
    drive0(1'b0, 8'hEE, 1'b1);
    for (int i = 0; i < 2; i++) begin
      settle();
      chk_rdy("bub_gap", 1'b1, 1'b0);
      tick();
      chk1("bub_gap_valid", out_valid, 1'b0);
    end
    drive0(1'b1, 8'hC2, 1'b1);
    tick();
    chk_beat("bub_c2", 8'hC2, 1'b1, 1'b0);
    drive0(1'b0, 8'h00, 1'b0);
    tick();
    chk_beat("bub_d1", 8'hD1, 1'b1, 1'b1);
    drive1(1'b0, 8'h00, 1'b0);
    tick();
    chk1("bub_drain", out_valid, 1'b0);

    // ---- backpressure: 0x5A held four cycles, then back-to-back reload ----
    drive0(1'b1, 8'h5A, 1'b1);
    tick();
    chk_beat("bp_load", 8'h5A, 1'b1, 1'b0);
    out_ready = 1'b0;
    drive0(1'b1, 8'h33, 1'b1);
    drive1(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_rdy("bp_hold", 1'b0, 1'b0);
      tick();
      chk_beat("bp_hold", 8'h5A, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    settle();
    chk_rdy("bp_release", 1'b0, 1'b1);
    tick();
    chk_beat("bp_77", 8'h77, 1'b0, 1'b1);
    drive1(1'b1, 8'h78, 1'b1);
    settle();
    chk_rdy("bp_lock1", 1'b0, 1'b1);
    tick();
    chk_beat("bp_78", 8'h78, 1'b1, 1'b1);
    drive1(1'b0, 8'h00, 1'b0);
    tick();
    chk_beat("bp_33", 8'h33, 1'b1, 1'b0);
    drive0(1'b0, 8'h00, 1'b0);
    tick();
    chk1("bp_drain", out_valid, 1'b0);

    // ---- single channel: ch1 sends 0x00..0x07 ----
    for (int i = 0; i < 8; i++) begin
      drive1(1'b1, 8'(i), 1'b1);
      settle();
      chk_rdy("solo", 1'b0, 1'b1);
      tick();
      chk_beat("solo", 8'(i), 1'b1, 1'b1);
    end
    drive1(1'b0, 8'h00, 1'b0);
    tick();
    chk1("solo_drain", out_valid, 1'b0);

    // ---- reset mid-packet drops the lock and the held beat ----
    drive0(1'b1, 8'hE1, 1'b0);
    tick();
    chk_beat("mid_e1", 8'hE1, 1'b0, 1'b0);
    drive0(1'b1, 8'hE2, 1'b1);
    drive1(1'b1, 8'hF1, 1'b1);
    settle();
    rst_n = 1'b0;
    settle();
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk8("mid_rst_data",  out_data,  8'h00);
    chk1("mid_rst_last",  out_last,  1'b0);
    chk1("mid_rst_src",   out_src,   1'b0);
    chk_rdy("mid_rst", 1'b0, 1'b0);
    settle();
    rst_n = 1'b1;
    in0_valid = 1'b0;
    settle();
    chk_rdy("mid_unlocked", 1'b0, 1'b1);
    in0_valid = 1'b1;
    settle();
    chk_rdy("mid_first", 1'b1, 1'b0);
    tick();
    chk_beat("mid_e2", 8'hE2, 1'b1, 1'b0);
    drive0(1'b0, 8'h00, 1'b0);
    tick();
    chk_beat("mid_f1", 8'hF1, 1'b1, 1'b1);
    drive1(1'b0, 8'h00, 1'b0);
    tick();
    chk1("mid_drain", out_valid, 1'b0);

    // ---- report ----
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/stream_merge_2to1.md
Name: stream_merge_2to1

Overview:
- Inverse of the team's 1:2 demux: merges two valid/ready input streams onto one output stream.
- Uses round-robin arbitration that is packet-aware. Once a channel is granted, the grant is held until that channel's `last` beat.
- Has a single registered output stage and tags each output beat with its source channel.
- Sits upstream of shared consumers (UART tx, memory port) that are fed by two producers.

Parameters:
- DATA_W, 8, width of data on each input and on the output.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in0_valid  in  1  channel 0 beat valid.
- in0_data  in  DATA_W  channel 0 data.
- in0_last  in  1  channel 0 final beat of packet.
- in0_ready  out  1  channel 0 beat accepted when in0_valid and in0_ready are both high.
- in1_valid  in  1  channel 1 beat valid.
- in1_data  in  DATA_W  channel 1 data.
- in1_last  in  1  channel 1 final beat of packet.
- in1_ready  out  1  channel 1 accept.
- out_valid  out  1  output beat valid (registered).
- out_data  out  DATA_W  output data (registered).
- out_last  out  1  output last (registered).
- out_src  out  1  source channel of the current output beat (registered).
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - FSM=IDLE, rr_ptr=0.
  - A reset mid-packet drops the lock and any held beat.
- load_en = !out_valid || out_ready. This is the combinational path out_ready -> inN_ready.
- inN_ready = load_en && grant==N. At most one inN_ready is high in any cycle.
- Beat accept on channel N: out_* <= inN_* on the next edge, and out_src <= N.
  - Latency is 1 cycle.
  - With out_ready held high, throughput is 1 beat/cycle.
- When load_en=1 and no channel is accepted: out_valid <= 0.
- When out_valid=1 and out_ready=0: all out_* hold stable, and neither input is readied.
- FSM states: IDLE, LOCK0, LOCK1.
  - IDLE grant:
    - Only in0_valid high: grant 0.
    - Only in1_valid high: grant 1.
    - Both high: grant rr_ptr.
    - Neither high: no grant.
  - IDLE, accept with last=0 on channel N: go to LOCKN.
  - IDLE, accept with last=1 on channel N: stay in IDLE, rr_ptr <= ~N.
  - LOCKN: grant is fixed to N.
    - The other channel's ready stays 0 even while inN_valid=0 (bubbles are allowed and the lock holds).
  - LOCKN, accept with last=1: go to IDLE, rr_ptr <= ~N.
- rr_ptr changes only on a packet end.
- Input data is sampled only on accept. Input values while not ready are ignored.
- Simultaneous out_ready and new accept in the same cycle: the old beat retires and the new beat loads on that edge (back-to-back, no bubble).

Decomposition:
- Shared package holds:
  - CH0=1'b0, CH1=1'b1.
  - FSM state enum: IDLE, LOCK0, LOCK1 (2 bits).
  - DATA_W default.
- One natural sub-module: rr_arb2, the 2-requester round-robin grant logic with a lock input and a grant output.
- The output register stays in the top module.

Test Plan:
- Reset check: assert rst_n=0 mid-stream -> all out_*=0 and both readies go low immediately. After release, channel 0 wins the first contention.
- Single-beat contention: both channels present single-beat packets continuously, with out_ready=1 -> out_data alternates ch0, ch1, ch0, … with out_src 0,1,0,1 at one beat per cycle.
- Packet lock: ch0 sends a 3-beat packet (A1,A2,A3) with last on A3, while ch1 holds valid with B1 -> output is A1,A2,A3,B1. in1_ready stays 0 until A3 is accepted.
- Lock bubble: ch0 packet with in0_valid low for 2 cycles between beats while ch1 is valid -> out_valid=0 for those cycles, no ch1 beat interleaves, and the lock holds.
- Backpressure: out_ready=0 for 4 cycles with data 0x5A held in the output register -> out_data/out_last/out_src stay stable and both readies are 0. When out_ready returns to 1, the next beat loads in the same cycle.
- Single channel idle: only ch1 active, with 8 single-beat packets 0x00..0x07 -> all pass in order with out_src=1. in0_ready never asserts.
